// File: rtl/btn_click_classifier_pkg.sv
// Shared types and constants for the button click classifier.
// Holds FSM encoding, click-count codes and the prescaler divide helper.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [1:0] CLK_0 = 2'd0;
    localparam logic [1:0] CLK_1 = 2'd1;
    localparam logic [1:0] CLK_2 = 2'd2;
    localparam logic [1:0] CLK_3 = 2'd3;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/btn_click_classifier_tick_gen.sv
// Free-running prescaler: o_tick is high for the one cycle the count sits at DIV-1.
// Latency: clr takes effect at the next edge (count 0 in the following cycle); no backpressure.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic o_tick
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/btn_click_classifier.sv
// Classifies bursts of debounced press pulses into single/double/triple click pulses.
// Latency: class pulse WINDOW_TICKS*DIV+1 cycles after the last press (triple: 2 cycles); no backpressure.
module btn_click_classifier
    import btn_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1_000,
    parameter int WINDOW_TICKS = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_pulse,
    output logic o_single,
    output logic o_double,
    output logic o_triple,
    output logic o_busy
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int TW  = $clog2(WINDOW_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(WINDOW_TICKS - 1);

    logic         btn_q;
    logic         press_q;
    logic         rise;
    logic         tick;
    logic         win_clr;
    state_t       state;
    logic [1:0]   click_cnt;
    logic [TW-1:0] tick_cnt;

    assign rise = i_btn_pulse & ~btn_q;

    // Rising edge is registered so no input path reaches the FSM combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            btn_q   <= i_btn_pulse;
            press_q <= rise;
        end
    end

    assign win_clr = press_q && (state != ST_EMIT);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr    (win_clr),
        .o_tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            click_cnt <= CLK_0;
            tick_cnt  <= '0;
            o_single  <= 1'b0;
            o_double  <= 1'b0;
            o_triple  <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            o_single <= 1'b0;
            o_double <= 1'b0;
            o_triple <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press_q) begin
                        click_cnt <= CLK_1;
                        tick_cnt  <= '0;
                        o_busy    <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A full count of three closes the burst before any window logic.
                    if (click_cnt == CLK_3) begin
                        o_triple <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= ST_EMIT;
                    end else if (press_q) begin
                        click_cnt <= (click_cnt == CLK_1) ? CLK_2 : CLK_3;
                        tick_cnt  <= '0;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == TICK_LAST) begin
                            o_single <= (click_cnt == CLK_1);
                            o_double <= (click_cnt == CLK_2);
                            o_busy   <= 1'b0;
                            state    <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    click_cnt <= CLK_0;
                    state     <= ST_IDLE;
                end
                default: begin
                    click_cnt <= CLK_0;
                    o_busy    <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_click_classifier.sv
// Directed and randomized bench for btn_click_classifier with DIV=10, WINDOW_TICKS=5.
// Expected pulses come from a burst-level model of the click timing rules.
module tb_btn_click_classifier;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int WT      = 5;
    localparam int WIN     = (CLK_HZ / TICK_HZ) * WT;
    localparam int MAXN    = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_btn_pulse = 1'b0;
    logic o_single, o_double, o_triple, o_busy;

    int tests = 0;
    int fails = 0;

    bit   in_w  [MAXN];
    bit   rst_w [MAXN];
    logic exp_s [MAXN];
    logic exp_d [MAXN];
    logic exp_t [MAXN];
    logic exp_b [MAXN];

    always #5 clk = ~clk;

    btn_click_classifier #(
        .CLK_HZ       (CLK_HZ),
        .TICK_HZ      (TICK_HZ),
        .WINDOW_TICKS (WT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_pulse (i_btn_pulse),
        .o_single    (o_single),
        .o_double    (o_double),
        .o_triple    (o_triple),
        .o_busy      (o_busy)
    );

    task automatic check(input string tag, input int c, input logic got, input logic expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s cycle %0d: got %b expected %b", tag, c, got, expv);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            in_w[i]  = 1'b0;
            rst_w[i] = 1'b0;
        end
    endtask

    // Burst model: a burst opens on a rising press, extends on presses within the
    // window, closes WIN+1 cycles after its last press or 2 cycles after a third press.
    function automatic void build_model(input int n);
        int  open, cnt, start, close_at, dropc;
        bit  prev, rise, lost;
        open = 0; cnt = 0; start = -1; close_at = -1; dropc = -1; prev = 1'b0;
        for (int c = 0; c < n; c++) begin
            exp_s[c] = 1'b0;
            exp_d[c] = 1'b0;
            exp_t[c] = 1'b0;
            exp_b[c] = 1'b0;
            if (rst_w[c]) begin
                open = 0; cnt = 0; prev = 1'b0; dropc = -1;
            end else begin
                if (open != 0 && c == close_at) begin
                    if (cnt == 1) exp_s[c] = 1'b1;
                    if (cnt == 2) exp_d[c] = 1'b1;
                    if (cnt == 3) exp_t[c] = 1'b1;
                    open  = 0;
                    dropc = c;
                end
                rise = in_w[c] && !prev;
                prev = in_w[c];
                lost = (c + 1 < n) && rst_w[c+1];
                if (rise && !lost && c != dropc) begin
                    if (open == 0) begin
                        open = 1; cnt = 1; start = c; close_at = c + WIN + 1;
                    end else if (cnt < 3) begin
                        cnt++;
                        close_at = (cnt == 3) ? c + 2 : c + WIN + 1;
                    end
                end
                exp_b[c] = (open != 0) && (c != start);
            end
        end
    endfunction

    task automatic run_case(input string name, input int n);
        build_model(n);
        rst = 1'b0;
        i_btn_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({name, "/rst_single"}, -1, o_single, 1'b0);
        check({name, "/rst_double"}, -1, o_double, 1'b0);
        check({name, "/rst_triple"}, -1, o_triple, 1'b0);
        check({name, "/rst_busy"},   -1, o_busy,   1'b0);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst = !rst_w[c];
            i_btn_pulse = in_w[c];
            @(posedge clk);
            #1;
            check({name, "/single"}, c, o_single, exp_s[c]);
            check({name, "/double"}, c, o_double, exp_d[c]);
            check({name, "/triple"}, c, o_triple, exp_t[c]);
            check({name, "/busy"},   c, o_busy,   exp_b[c]);
        end
    endtask

    task automatic gen_random(input int n);
        int pos, d, w, wmax;
        int dl[8] = '{2, 3, 11, 49, 50, 51, 52, 60};
        clear_stim();
        pos = $urandom_range(2, 20);
        while (pos < n - 70) begin
            if ($urandom_range(0, 1) == 0) d = dl[$urandom_range(0, 7)];
            else d = $urandom_range(2, 70);
            wmax = (d - 1 < 3) ? d - 1 : 3;
            w = $urandom_range(1, wmax);
            for (int k = 0; k < w; k++) in_w[pos + k] = 1'b1;
            pos += d;
        end
    endtask

    initial begin
        // 1: lone press
        clear_stim();
        in_w[10] = 1'b1;
        run_case("single", 120);

        // 2: two presses inside the window
        clear_stim();
        in_w[10] = 1'b1; in_w[40] = 1'b1;
        run_case("double", 150);

        // 3: three presses, a fourth landing on the emit cycle
        clear_stim();
        in_w[10] = 1'b1; in_w[30] = 1'b1; in_w[50] = 1'b1; in_w[52] = 1'b1;
        run_case("triple", 160);

        // 4: held-high input counts once
        clear_stim();
        for (int i = 10; i <= 25; i++) in_w[i] = 1'b1;
        run_case("held", 120);

        // 5: second press coincides with window expiry
        clear_stim();
        in_w[10] = 1'b1; in_w[60] = 1'b1;
        run_case("expiry_tie", 170);

        // 6: reset mid-burst, then a fresh single
        clear_stim();
        in_w[10] = 1'b1; in_w[50] = 1'b1;
        rst_w[30] = 1'b1; rst_w[31] = 1'b1; rst_w[32] = 1'b1;
        run_case("reset_mid", 160);

        for (int r = 0; r < 6; r++) begin
            gen_random(MAXN);
            run_case($sformatf("rand%0d", r), MAXN);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
